uart_tx_arbiter: RTL

//  Shares one UART transmit line between NREQ byte-stream requesters (per-core/per-agent debug print).

---
 rtl/uart_arb_pkg.sv | 14 +
 rtl/uart_tx_serializer.sv | 84 ++++++++
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_LOCKED, ARB_RELEASE} arb_state_e;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_e;

  localparam int         FRAME_BITS = 10;
  localparam logic [7:0] NEWLINE    = 8'h0A;

  function automatic int cps(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: byte in on valid/ready, LSB first, each bit held CPS clocks.
module uart_tx_serializer
  import uart_arb_pkg::*;
#(
  parameter int CPS = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int              CW        = (CPS > 1) ? $clog2(CPS) : 1;
  localparam logic [CW-1:0]   CYC_LAST  = CW'(CPS - 1);
  localparam logic [3:0]      LAST_DATA = 4'(FRAME_BITS - 2);

  ser_state_e    state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          bit_end, accept;

  assign bit_end = (cyc_q == CYC_LAST);
  // Ready in the last stop cycle lets the next start bit follow with no gap.
  assign ready_o = (state_q == S_IDLE) || ((state_q == S_STOP) && bit_end);
  assign busy_o  = (state_q != S_IDLE);
  assign tx_o    = tx_q;
  assign accept  = valid_i && ready_o;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    if (state_q != S_IDLE) begin
      cyc_d = bit_end ? '0 : cyc_q + 1'b1;
      if (bit_end) begin
        bit_d = bit_q + 4'd1;
        if (state_q == S_STOP) begin
          state_d = S_IDLE;
          bit_d   = '0;
          tx_d    = 1'b1;
        end else if (bit_q == LAST_DATA) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          state_d = S_DATA;
          tx_d    = data_q[bit_q[2:0]];
        end
      end
    end
    if (accept) begin
      state_d = S_START;
      cyc_d   = '0;
      bit_d   = '0;
      data_d  = data_i;
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, line-locked sharing of one 8N1 UART transmitter among NREQ requesters.
// Optional idle-owner forced release is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int FREQ         = 50000000,
  parameter int BAUD         = 115200,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*8-1:0]       req_data_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic                    tx_o,
  output logic                    busy_o,
  output logic [$clog2(NREQ)-1:0] owner_o,
  output logic                    owner_valid_o
);

  localparam int CPS = cps(FREQ, BAUD);
  localparam int OW  = $clog2(NREQ);

  if (CPS < 2) begin : g_bad_cps
    $error("uart_tx_arbiter: FREQ/BAUD must give at least 2 clocks per bit");
  end
  if (NREQ < 2) begin : g_bad_nreq
    $error("uart_tx_arbiter: NREQ must be at least 2");
  end
  if (HOLD_TIMEOUT < 1) begin : g_bad_hold
    $error("uart_tx_arbiter: HOLD_TIMEOUT must be at least 1");
  end

  arb_state_e    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d, last_q, last_d, pick;
  logic          found, tmo;
  logic          ser_valid, ser_ready, ser_busy, ser_accept;
  logic [7:0]    ser_data;
  int            cand;

  assign ser_data      = req_data_i[{owner_q, 3'b000} +: 8];
  assign ser_valid     = (state_q == ARB_LOCKED) && req_valid_i[owner_q];
  assign ser_accept    = ser_valid && ser_ready;
  assign owner_o       = owner_q;
  assign owner_valid_o = (state_q != ARB_IDLE);

  always_comb begin
    req_ready_o = '0;
    if (state_q == ARB_LOCKED) req_ready_o[owner_q] = ser_ready;
  end

  // First valid requester at or after last_owner+1, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_q) + k) % NREQ;
      if (!found && req_valid_i[OW'(cand)]) begin
        found = 1'b1;
        pick  = OW'(cand);
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(HOLD_TIMEOUT + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;

  always_comb begin
    tcnt_d = tcnt_q;
    tmo    = 1'b0;
    if ((state_q != ARB_LOCKED) || ser_accept) begin
      tcnt_d = '0;
    end else if (!ser_busy && !req_valid_i[owner_q]) begin
      tcnt_d = tcnt_q + 1'b1;
      tmo    = (tcnt_d == TW'(HOLD_TIMEOUT));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) tcnt_q <= '0;
    else         tcnt_q <= tcnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          owner_d = pick;
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if ((ser_accept && (ser_data == NEWLINE)) || tmo) state_d = ARB_RELEASE;
      end
      ARB_RELEASE: begin
        if (!ser_busy) begin
          last_d  = owner_q;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      last_q  <= OW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  uart_tx_serializer #(
    .CPS(CPS)
  ) u_ser (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .valid_i(ser_valid),
    .data_i (ser_data),
    .ready_o(ser_ready),
    .tx_o   (tx_o),
    .busy_o (ser_busy)
  );

  assign busy_o = ser_busy;

endmodule
